mem_access_ctrl: RTL and testbench

- Memory-stage controller; consumes the execute-stage result (ALU_res as address, read2data as store data) for LD/ST instructions.
- Runs the Rd/Wr/Stall/Done handshake with the stalling cache (mem_system).
- Stalls the pipeline until the access completes, then presents write-back data.
- Non-memory instructions pass ALU_res straight through.

---
 rtl/mem_access_ctrl_pkg.sv | 23 ++
 rtl/mem_access_ctrl_sat_counter.sv | 35 +++
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM state and request-op
// encodings, default data width and the access legality helper.
package mem_access_ctrl_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } op_e;

  // Word accesses only: conflicting load+store or an odd address are rejected.
  function automatic logic access_bad(input logic rd, input logic wr, input logic addr_lsb);
    return (rd & wr) | ((rd | wr) & addr_lsb);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count, frozen at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues one LD/ST at a time to a stalling cache and
// holds the pipeline until it completes. Optional perf counters: MEM_PERF_CNT_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              Halt,
  input  logic [DATA_W-1:0] ALU_res,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_DataOut,
  input  logic              mem_Done,
  input  logic              mem_Stall,
  input  logic              mem_CacheHit,
  input  logic              mem_Err,
  output logic [DATA_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_DataIn,
  output logic              mem_Rd,
  output logic              mem_Wr,
  output logic              stall_pipe,
  output logic [DATA_W-1:0] mem_res,
  output logic              err
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  hit_cnt
`endif
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  logic              bad_s;
  logic              req_s;
  logic              stall_s;
  logic              err_s;
  logic              done_s;
  logic [DATA_W-1:0] res_s;

  // Next-state, capture and combinational handshake outputs.
  always_comb begin
    bad_s   = access_bad(MemRead, MemWrite, ALU_res[0]);
    req_s   = (MemRead | MemWrite) & ~Halt & ~bad_s;
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;
    stall_s = 1'b0;
    err_s   = 1'b0;
    done_s  = 1'b0;
    res_s   = ALU_res;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          stall_s = 1'b1;
          addr_d  = ALU_res;
          din_d   = wr_data;
          op_d    = MemRead ? RD : WR;
          state_d = BUSY;
        end else begin
          err_s = bad_s & ~Halt;
        end
      end
      BUSY: begin
        // mem_Done is authoritative; mem_Err aborts even without it.
        stall_s = ~mem_Done & ~mem_Err;
        err_s   = mem_Err;
        done_s  = mem_Done;
        if (mem_Done) begin
          res_s = (op_q == RD) ? mem_DataOut : addr_q;
          rd_d  = mem_DataOut;
        end else begin
          res_s = ALU_res;
        end
        if (mem_Done || mem_Err) begin
          state_d = IDLE;
          op_d    = NONE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        op_d    = NONE;
      end
    endcase
  end

  // Controller state and captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= NONE;
      addr_q  <= {DATA_W{1'b0}};
      din_q   <= {DATA_W{1'b0}};
      rd_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
    end
  end

  assign mem_Addr   = addr_q;
  assign mem_DataIn = din_q;
  assign mem_Rd     = (state_q == BUSY) && (op_q == RD);
  assign mem_Wr     = (state_q == BUSY) && (op_q == WR);
  // Reset must release the pipeline immediately, even with a load still presented.
  assign stall_pipe = rst_n & stall_s;
  assign err        = rst_n & err_s;
  assign mem_res    = res_s;

`ifdef MEM_PERF_CNT_EN
  sat_counter #(.CNT_W(CNT_W)) u_acc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_s),
    .cnt   (acc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (done_s & mem_CacheHit),
    .cnt   (hit_cnt)
  );

  logic unused_s;
  assign unused_s = ^{mem_Stall, rd_q};
`else
  logic unused_s;
  assign unused_s = ^{mem_Stall, mem_CacheHit, rd_q, done_s, 1'(CNT_W > 0)};
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed per-cycle vector table, a reset-mid-access
// sequence, then random traffic against a transaction-level reference model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        MemRead, MemWrite, Halt;
  logic [15:0] ALU_res, wr_data, mem_DataOut;
  logic        mem_Done, mem_Stall, mem_CacheHit, mem_Err;
  logic [15:0] mem_Addr, mem_DataIn, mem_res;
  logic        mem_Rd, mem_Wr, stall_pipe, err;
`ifdef MEM_PERF_CNT_EN
  logic [15:0] acc_cnt, hit_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.DATA_W(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Halt         (Halt),
    .ALU_res      (ALU_res),
    .wr_data      (wr_data),
    .mem_DataOut  (mem_DataOut),
    .mem_Done     (mem_Done),
    .mem_Stall    (mem_Stall),
    .mem_CacheHit (mem_CacheHit),
    .mem_Err      (mem_Err),
    .mem_Addr     (mem_Addr),
    .mem_DataIn   (mem_DataIn),
    .mem_Rd       (mem_Rd),
    .mem_Wr       (mem_Wr),
    .stall_pipe   (stall_pipe),
    .mem_res      (mem_res),
    .err          (err)
`ifdef MEM_PERF_CNT_EN
    ,
    .acc_cnt      (acc_cnt),
    .hit_cnt      (hit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        mr, mw, halt;
    bit [15:0] alu, wd;
    bit        done;
    bit [15:0] dout;
    bit        hit, merr;
    bit        e_rd, e_wr, e_stall, e_err, chk_res;
    bit [15:0] e_res, e_addr, e_din;
    int        e_acc, e_hit;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit mr, input bit mw, input bit h, input bit [15:0] alu,
                       input bit [15:0] wd, input bit dn, input bit [15:0] dout,
                       input bit hit, input bit me);
    MemRead = mr; MemWrite = mw; Halt = h; ALU_res = alu; wr_data = wd;
    mem_Done = dn; mem_DataOut = dout; mem_CacheHit = hit; mem_Err = me;
    mem_Stall = ~dn;
  endtask

  // Reference model state: one pending transaction at most.
  bit        m_busy, m_rd;
  bit [15:0] m_addr, m_din;
  int        m_acc, m_hit;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0777, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1;
    chk("rst_rd", 32'(mem_Rd), 32'd0);
    chk("rst_wr", 32'(mem_Wr), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_Addr), 32'd0);
    chk("rst_din", 32'(mem_DataIn), 32'd0);
    chk("rst_res", 32'(mem_res), 32'h0777);

    //               mr    mw    h     alu       wd        dn    dout      hit   me    rd    wr    st    er    cr    res       addr      din       acc hit
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h5678, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5678, 16'h0000, 16'h0000, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h0000, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 16'h0040, 16'h0000, 0, 0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0040, 16'h0000, 1, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0102, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0102, 16'h0040, 16'h0000, 1, 1});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0102, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0102, 16'hA5A5, 1, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0102, 16'hA5A5, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0102, 16'h0102, 16'hA5A5, 1, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0102, 16'hA5A5, 2, 1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0102, 16'hA5A5, 2, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h0102, 16'hA5A5, 2, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0021, 16'h0102, 16'hA5A5, 2, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0102, 16'hA5A5, 2, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1111, 16'h0010, 16'h0000, 2, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 16'h0012, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0012, 16'h0010, 16'h0000, 3, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0012, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0012, 16'h2222, 3, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0012, 16'h2222, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0012, 16'h0012, 16'h2222, 3, 1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 16'h0014, 16'h3333, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0014, 16'h0012, 16'h2222, 4, 1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0ABC, 16'h0012, 16'h2222, 4, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 16'h0012, 16'h2222, 4, 1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0030, 16'h0000, 4, 1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0030, 16'h0000, 4, 1});

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].mr, vecs[i].mw, vecs[i].halt, vecs[i].alu, vecs[i].wd,
            vecs[i].done, vecs[i].dout, vecs[i].hit, vecs[i].merr);
      #1;
      chk($sformatf("v%0d_rd", i), 32'(mem_Rd), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_wr", i), 32'(mem_Wr), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_stall", i), 32'(stall_pipe), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
      chk($sformatf("v%0d_addr", i), 32'(mem_Addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_din", i), 32'(mem_DataIn), 32'(vecs[i].e_din));
      if (vecs[i].chk_res) chk($sformatf("v%0d_res", i), 32'(mem_res), 32'(vecs[i].e_res));
`ifdef MEM_PERF_CNT_EN
      chk($sformatf("v%0d_acc", i), 32'(acc_cnt), 32'(vecs[i].e_acc));
      chk($sformatf("v%0d_hit", i), 32'(hit_cnt), 32'(vecs[i].e_hit));
`endif
    end

    // Reset during the BUSY phase of a miss, with the load still presented.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #1 chk("mid_issue_stall", 32'(stall_pipe), 32'd1);
    @(negedge clk);
    #1 chk("mid_busy_rd", 32'(mem_Rd), 32'd1);
    chk("mid_busy_addr", 32'(mem_Addr), 32'h0050);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(mem_Rd), 32'd0);
    chk("mid_rst_stall", 32'(stall_pipe), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_addr", 32'(mem_Addr), 32'd0);
    chk("post_rst_rd", 32'(mem_Rd), 32'd0);
    chk("post_rst_stall", 32'(stall_pipe), 32'd0);
`ifdef MEM_PERF_CNT_EN
    chk("post_rst_acc", 32'(acc_cnt), 32'd0);
    chk("post_rst_hit", 32'(hit_cnt), 32'd0);
`endif

    // Random traffic against the transaction model.
    m_busy = 1'b0; m_rd = 1'b0; m_addr = 16'h0000; m_din = 16'h0000; m_acc = 0; m_hit = 0;
    for (int c = 0; c < 2000; c++) begin
      bit        mr, mw, h, dn, hit, me, req, e_rd, e_wr, e_stall, e_err, res_ok;
      bit [15:0] alu, wd, dout, e_res;
      int        sel;
      @(negedge clk);
      sel  = int'($urandom_range(0, 9));
      mr   = (sel < 4) || (sel == 9);
      mw   = (sel >= 4 && sel < 7) || (sel == 9 && $urandom_range(0, 3) == 0);
      h    = ($urandom_range(0, 9) == 0);
      alu  = 16'($urandom);
      if ($urandom_range(0, 4) != 0) alu[0] = 1'b0;
      wd   = 16'($urandom);
      dn   = ($urandom_range(0, 4) < 2);
      dout = 16'($urandom);
      hit  = $urandom_range(0, 1) == 1;
      me   = ($urandom_range(0, 19) == 0);
      drive(mr, mw, h, alu, wd, dn, dout, hit, me);
      #1;
      if (!m_busy) begin
        req     = (mr || mw) && !h && !(mr && mw) && !alu[0];
        e_rd    = 1'b0;
        e_wr    = 1'b0;
        e_stall = req;
        e_err   = (mr || mw) && !h && ((mr && mw) || alu[0]);
        e_res   = alu;
        res_ok  = 1'b1;
      end else begin
        req     = 1'b0;
        e_rd    = m_rd;
        e_wr    = !m_rd;
        e_stall = !dn && !me;
        e_err   = me;
        e_res   = m_rd ? dout : m_addr;
        res_ok  = dn;
      end
      chk("rnd_rd", 32'(mem_Rd), 32'(e_rd));
      chk("rnd_wr", 32'(mem_Wr), 32'(e_wr));
      chk("rnd_stall", 32'(stall_pipe), 32'(e_stall));
      chk("rnd_err", 32'(err), 32'(e_err));
      chk("rnd_addr", 32'(mem_Addr), 32'(m_addr));
      chk("rnd_din", 32'(mem_DataIn), 32'(m_din));
      chk("rnd_rdwr_excl", 32'(mem_Rd & mem_Wr), 32'd0);
      if (res_ok) chk("rnd_res", 32'(mem_res), 32'(e_res));
`ifdef MEM_PERF_CNT_EN
      chk("rnd_acc", 32'(acc_cnt), 32'(m_acc));
      chk("rnd_hit", 32'(hit_cnt), 32'(m_hit));
`endif
      if (!m_busy && req) begin
        m_busy = 1'b1; m_rd = mr; m_addr = alu; m_din = wd;
      end else if (m_busy && (dn || me)) begin
        m_busy = 1'b0;
        if (dn) begin
          if (m_acc < 65535) m_acc++;
          if (hit && m_hit < 65535) m_hit++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
